// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: FSM states, capture modes and the
// record layout presented on rd_data.
package trace_pkg;

    localparam int unsigned REC_DATA_W = 32;
    localparam int unsigned REC_REG_W  = 5;

    localparam logic FILL    = 1'b0;
    localparam logic TRIGGER = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_t;

    // Field order matches rd_data MSB to LSB for the default widths.
    typedef struct packed {
        logic                  memwrite;
        logic                  regwrite;
        logic [REC_REG_W-1:0]  writereg;
        logic [REC_DATA_W-1:0] writedata;
        logic [REC_DATA_W-1:0] instr;
    } commit_rec_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit input bus and valid/ready drain port of the commit trace buffer.
interface commit_trace_buffer_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    localparam int unsigned REC_W = 2 + REG_ADDR_W + 2 * DATA_W;

    logic                  commit_valid;
    logic [DATA_W-1:0]     commit_instr;
    logic                  commit_regwrite;
    logic [REG_ADDR_W-1:0] commit_writereg;
    logic [DATA_W-1:0]     commit_writedata;
    logic                  commit_memwrite;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [REC_W-1:0]      rd_data;

    modport master (
        output commit_valid, commit_instr, commit_regwrite, commit_writereg,
               commit_writedata, commit_memwrite, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  commit_valid, commit_instr, commit_regwrite, commit_writereg,
               commit_writedata, commit_memwrite, rd_ready,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port, no reset.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned REC_W = 71,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [REC_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [REC_W-1:0] rdata
);
    logic [REC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/commit_trace_buffer.sv
// Capture buffer for committed instructions: fill-until-full or circular
// pre/post-trigger capture, drained oldest-first through a show-ahead port.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned POST_TRIG  = 4,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = AW + 1,
    localparam int unsigned REC_W     = 2 + REG_ADDR_W + 2 * DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 mode,
    input  logic [DATA_W-1:0]    trig_mask,
    input  logic [DATA_W-1:0]    trig_value,
    commit_trace_buffer_if.slave bus,
    output logic [CW-1:0]        count,
    output logic                 triggered,
    output logic                 overflow,
    output logic                 done
);
    trace_state_t      state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     post_q, post_d;
    logic              triggered_q, triggered_d;
    logic              overflow_q, overflow_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] value_q, value_d;

    logic              we_c;
    logic              match_c;
    logic              full_c;
    logic              pop_c;
    logic [REC_W-1:0]  rec_c;
    logic [REC_W-1:0]  ram_rdata;

    assign match_c = ((bus.commit_instr & mask_q) == (value_q & mask_q));
    assign full_c  = (count_q == CW'(DEPTH));
    assign pop_c   = bus.rd_valid & bus.rd_ready;
    assign rec_c   = {bus.commit_memwrite, bus.commit_regwrite, bus.commit_writereg,
                      bus.commit_writedata, bus.commit_instr};

    trace_ram #(.DEPTH(DEPTH), .REC_W(REC_W)) u_ram (
        .clk   (clk),
        .we    (we_c),
        .waddr (wr_ptr_q),
        .wdata (rec_c),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            mode_q      <= FILL;
            mask_q      <= '0;
            value_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
        end
    end

    // Arm wins over everything, including a commit in the same cycle.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        value_d     = value_q;
        we_c        = 1'b0;

        if (arm) begin
            state_d     = ARMED;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            post_d      = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
            mode_d      = mode;
            mask_d      = trig_mask;
            value_d     = trig_value;
        end else begin
            unique case (state_q)
                ARMED, POST: begin
                    if (bus.commit_valid) begin
                        we_c     = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (mode_q == FILL) begin
                            count_d = count_q + 1'b1;
                            if (count_q == CW'(DEPTH - 1)) state_d = DONE;
                        end else begin
                            // Circular: when full the oldest record is overwritten.
                            if (full_c) begin
                                rd_ptr_d   = rd_ptr_q + 1'b1;
                                overflow_d = 1'b1;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                            if (state_q == POST) begin
                                post_d = post_q - 1'b1;
                                if (post_q == AW'(1)) state_d = DONE;
                            end else if (match_c) begin
                                triggered_d = 1'b1;
                                if (POST_TRIG == 0) begin
                                    state_d = DONE;
                                end else begin
                                    post_d  = AW'(POST_TRIG);
                                    state_d = POST;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (pop_c) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count        = count_q;
    assign triggered    = triggered_q;
    assign overflow     = overflow_q;
    assign done         = (state_q == DONE);
    assign bus.rd_valid = done && (count_q != '0);
    assign bus.rd_data  = bus.rd_valid ? ram_rdata : '0;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: table-driven capture scenarios with a
// queue scoreboard of expected records, plus re-arm and async-reset sequences.
module tb_commit_trace_buffer;
    import trace_pkg::*;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned POST_TRIG  = 2;
    localparam int unsigned CW         = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              arm;
    logic              mode;
    logic [DATA_W-1:0] trig_mask;
    logic [DATA_W-1:0] trig_value;
    logic [CW-1:0]     count;
    logic              triggered;
    logic              overflow;
    logic              done;

    commit_trace_buffer_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

    commit_trace_buffer #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .mode       (mode),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .bus        (bus),
        .count      (count),
        .triggered  (triggered),
        .overflow   (overflow),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rec(input string name, input commit_rec_t act, input commit_rec_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: records the buffer should hold, oldest first.
    commit_rec_t  exp_q[$];
    bit           m_active, m_post_phase, m_done, m_trig, m_ovf, m_mode;
    int           m_post;
    logic [31:0]  m_mask, m_val;

    function automatic commit_rec_t mk_rec(input int i);
        commit_rec_t r;
        r.instr     = 32'h100 + 32'(i);
        r.writereg  = 5'(i);
        r.writedata = 32'hA000 + 32'(i);
        r.regwrite  = 1'b1;
        r.memwrite  = ((i % 3) == 0);
        return r;
    endfunction

    function automatic void model_commit(input int i);
        commit_rec_t r;
        r = mk_rec(i);
        if (!m_active) return;
        if (m_mode == FILL) begin
            exp_q.push_back(r);
            if (exp_q.size() == int'(DEPTH)) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else begin
            if (exp_q.size() == int'(DEPTH)) begin
                void'(exp_q.pop_front());
                m_ovf = 1'b1;
            end
            exp_q.push_back(r);
            if (m_post_phase) begin
                m_post--;
                if (m_post == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if ((r.instr & m_mask) == (m_val & m_mask)) begin
                m_trig = 1'b1;
                if (POST_TRIG == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_post_phase = 1'b1;
                    m_post       = int'(POST_TRIG);
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input bit md, input logic [31:0] msk, input logic [31:0] val);
        arm        = 1'b1;
        mode       = md;
        trig_mask  = msk;
        trig_value = val;
        exp_q.delete();
        m_active = 1'b1; m_post_phase = 1'b0; m_done = 1'b0;
        m_trig = 1'b0; m_ovf = 1'b0; m_mode = md; m_post = 0;
        m_mask = msk; m_val = val;
        step();
        arm = 1'b0;
    endtask

    task automatic do_commit(input int i);
        commit_rec_t r;
        r = mk_rec(i);
        bus.commit_valid     = 1'b1;
        bus.commit_instr     = r.instr;
        bus.commit_regwrite  = r.regwrite;
        bus.commit_writereg  = r.writereg;
        bus.commit_writedata = r.writedata;
        bus.commit_memwrite  = r.memwrite;
        model_commit(i);
        step();
        bus.commit_valid = 1'b0;
    endtask

    // Drain with a repeating 4-cycle ready pattern; hold-stability is checked on stalls.
    task automatic drain(input logic [3:0] pat, input int exp_n);
        commit_rec_t held;
        bit          hold = 1'b0;
        int          got = 0;
        int          cyc = 0;
        while (bus.rd_valid && cyc < 64) begin
            if (hold) check_rec("rd_data_stable", bus.rd_data, held);
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL drain_extra: got record %h expected none", bus.rd_data);
                break;
            end
            check_rec("drain_order", bus.rd_data, exp_q[0]);
            bus.rd_ready = pat[cyc % 4];
            if (bus.rd_ready) begin
                void'(exp_q.pop_front());
                got++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                held = bus.rd_data;
            end
            step();
            cyc++;
        end
        bus.rd_ready = 1'b0;
        check("drain_count", 32'(got), 32'(exp_n));
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("post_drain_valid", 32'(bus.rd_valid), 32'd0);
        check("post_drain_data_zero", 32'(bus.rd_data != '0), 32'd0);
        check("post_drain_count", 32'(count), 32'd0);
        check("post_drain_done", 32'(done), 32'd1);
    endtask

    typedef struct {
        bit          md;
        logic [31:0] mask;
        logic [31:0] val;
        int          n;
        int          exp_count;
        bit          exp_trig;
        bit          exp_ovf;
        bit          exp_done;
        logic [3:0]  pat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{FILL,    32'h0,        32'h0,   10, 8, 1'b0, 1'b0, 1'b1, 4'b1001};
        vecs[1] = '{TRIGGER, 32'hFFFFFFFF, 32'h10C, 20, 8, 1'b1, 1'b1, 1'b1, 4'b1111};
        vecs[2] = '{TRIGGER, 32'h0,        32'h0,   10, 3, 1'b1, 1'b0, 1'b1, 4'b1011};
        vecs[3] = '{TRIGGER, 32'hFFFFFFFF, 32'h1FF,  5, 5, 1'b0, 1'b0, 1'b0, 4'b1111};
        vecs[4] = '{FILL,    32'h0,        32'h0,    3, 3, 1'b0, 1'b0, 1'b0, 4'b1111};

        reset = 1'b1; arm = 1'b0; mode = FILL; trig_mask = '0; trig_value = '0;
        bus.commit_valid = 1'b0; bus.commit_instr = '0; bus.commit_regwrite = 1'b0;
        bus.commit_writereg = '0; bus.commit_writedata = '0; bus.commit_memwrite = 1'b0;
        bus.rd_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check("reset_count", 32'(count), 32'd0);
        check("reset_flags", 32'({triggered, overflow, done, bus.rd_valid}), 32'd0);
        check("reset_rd_data_zero", 32'(bus.rd_data != '0), 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_arm(vecs[v].md, vecs[v].mask, vecs[v].val);
            check("arm_count", 32'(count), 32'd0);
            for (int i = 0; i < vecs[v].n; i++) begin
                do_commit(i);
                check($sformatf("v%0d_c%0d_count", v, i), 32'(count), 32'(exp_q.size()));
                check($sformatf("v%0d_c%0d_trig", v, i), 32'(triggered), 32'(m_trig));
                check($sformatf("v%0d_c%0d_done", v, i), 32'(done), 32'(m_done));
            end
            check($sformatf("v%0d_count", v), 32'(count), 32'(vecs[v].exp_count));
            check($sformatf("v%0d_triggered", v), 32'(triggered), 32'(vecs[v].exp_trig));
            check($sformatf("v%0d_overflow", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_rd_valid", v), 32'(bus.rd_valid), 32'(vecs[v].exp_done));
            if (vecs[v].exp_done) drain(vecs[v].pat, vecs[v].exp_count);
        end

        // Arm together with a commit: the commit is dropped.
        arm = 1'b1; mode = FILL; trig_mask = '0; trig_value = '0;
        bus.commit_valid = 1'b1; bus.commit_instr = 32'h100;
        step();
        arm = 1'b0; bus.commit_valid = 1'b0;
        check("same_cycle_count", 32'(count), 32'd0);
        check("same_cycle_done", 32'(done), 32'd0);

        // Re-arm during POST clears triggered and returns to capture.
        do_arm(TRIGGER, 32'hFFFFFFFF, 32'h103);
        for (int i = 0; i < 4; i++) do_commit(i);
        check("rearm_pre_trig", 32'(triggered), 32'd1);
        check("rearm_pre_done", 32'(done), 32'd0);
        do_arm(TRIGGER, 32'hFFFFFFFF, 32'h1FF);
        check("rearm_trig_cleared", 32'(triggered), 32'd0);
        check("rearm_count_cleared", 32'(count), 32'd0);
        do_commit(5);
        check("rearm_captures", 32'(count), 32'd1);
        check("rearm_not_done", 32'(done), 32'd0);

        // Async reset mid-POST, checked before the next rising edge.
        do_arm(TRIGGER, 32'h0, 32'h0);
        do_commit(0);
        check("ar_pre_trig", 32'(triggered), 32'd1);
        check("ar_pre_count", 32'(count), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_flags", 32'({triggered, overflow, done, bus.rd_valid}), 32'd0);
        check("ar_rd_data_zero", 32'(bus.rd_data != '0), 32'd0);
        step();
        reset = 1'b0;
        do_commit(1);
        check("ar_idle_ignores_commit", 32'(count), 32'd0);
        check("ar_idle_not_done", 32'(done), 32'd0);
        check("ar_idle_no_trig", 32'(triggered), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
